pacman_input_ctrl: RTL and testbench



---
 rtl/pacman_input_pkg.sv | 40 ++++
 rtl/pacman_input_ctrl_if.sv | 20 ++
 rtl/button_debouncer.sv | 90 +++++++++
 rtl/pacman_input_ctrl.sv | 85 ++++++++
 tb/tb_pacman_input_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_input_pkg.sv
// rtl/pacman_input_pkg.sv - shared types and constants for the Pac-Man input front-end
package pacman_input_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        S_LO = 2'd0,
        W_HI = 2'd1,
        S_HI = 2'd2,
        W_LO = 2'd3
    } db_state_t;

    localparam int BTN_DOWN   = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int NUM_BTN    = 5;

    // Returns {up, down, left, right}; NONE maps to all zero.
    function automatic logic [3:0] dir_decode(input dir_t d);
        logic [3:0] oh;
        oh = 4'b0000;
        case (d)
            UP:      oh = 4'b1000;
            DOWN:    oh = 4'b0100;
            LEFT:    oh = 4'b0010;
            RIGHT:   oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pacman_input_ctrl_if.sv
// rtl/pacman_input_ctrl_if.sv - game-side bundle between input front-end and block controller
interface pacman_input_ctrl_if;
    logic dir_clear;
    logic up;
    logic down;
    logic left;
    logic right;
    logic move_tick;
    logic paused;

    modport master (
        input  dir_clear,
        output up, down, left, right, move_tick, paused
    );

    modport slave (
        output dir_clear,
        input  up, down, left, right, move_tick, paused
    );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus stable-count debounce FSM for one button
module button_debouncer
    import pacman_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    db_state_t       state;
    db_state_t       state_nx;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_nx;
    logic            db_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= S_LO;
            cnt   <= '0;
            db    <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            state <= state_nx;
            cnt   <= cnt_nx;
            db    <= db_nx;
            // Rising edge of the registered level: one pulse per accepted press.
            press <= db_nx & ~db;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        db_nx    = (state == S_HI) || (state == W_LO);
        case (state)
            S_LO: begin
                if (sync2) begin
                    state_nx = W_HI;
                    cnt_nx   = '0;
                end
            end
            W_HI: begin
                if (!sync2) begin
                    state_nx = S_LO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_HI;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + DB_W'(1);
                end
            end
            S_HI: begin
                if (!sync2) begin
                    state_nx = W_LO;
                    cnt_nx   = '0;
                end
            end
            W_LO: begin
                if (sync2) begin
                    state_nx = S_HI;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_LO;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + DB_W'(1);
                end
            end
            default: begin
                state_nx = S_LO;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pacman_input_ctrl.sv
// rtl/pacman_input_ctrl.sv - debounced buttons, latched direction, pause toggle and move strobe
module pacman_input_ctrl
    import pacman_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_center,
    pacman_input_ctrl_if.master   game,
    output logic [NUM_BTN-1:0]    btn_db
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    dir_t               dir_q;
    dir_t               dir_nx;
    logic               paused_q;
    logic [TK_W-1:0]    tick_cnt;
    logic               tick_q;

    assign raw[BTN_DOWN]   = btn_down;
    assign raw[BTN_UP]     = btn_up;
    assign raw[BTN_LEFT]   = btn_left;
    assign raw[BTN_RIGHT]  = btn_right;
    assign raw[BTN_CENTER] = btn_center;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(raw[i]),
            .db     (btn_db[i]),
            .press  (press[i])
        );
    end

    // A fresh press always beats a wall-hit clear landing in the same cycle.
    always_comb begin
        dir_nx = dir_q;
        if (press[BTN_RIGHT]) begin
            dir_nx = RIGHT;
        end else if (press[BTN_LEFT]) begin
            dir_nx = LEFT;
        end else if (press[BTN_UP]) begin
            dir_nx = UP;
        end else if (press[BTN_DOWN]) begin
            dir_nx = DOWN;
        end else if (game.dir_clear) begin
            dir_nx = NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q    <= NONE;
            paused_q <= 1'b0;
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            dir_q    <= dir_nx;
            paused_q <= paused_q ^ press[BTN_CENTER];
            tick_cnt <= (tick_cnt == TK_LAST) ? '0 : tick_cnt + TK_W'(1);
            // Counter keeps running while paused so ticks resume on the original grid.
            tick_q   <= (tick_cnt == TK_LAST) & ~paused_q;
        end
    end

    assign {game.up, game.down, game.left, game.right} = dir_decode(dir_q);
    assign game.move_tick = tick_q;
    assign game.paused    = paused_q;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// tb/tb_pacman_input_ctrl.sv - self-checking bench for pacman_input_ctrl
module tb_pacman_input_ctrl;

    localparam int N = 4;
    localparam int T = 8;

    localparam logic [4:0] B_DOWN   = 5'b00001;
    localparam logic [4:0] B_UP     = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b01000;
    localparam logic [4:0] B_CENTER = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_center = 1'b0;
    logic [4:0] btn_db;

    pacman_input_ctrl_if gif ();

    pacman_input_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .TICK_CYCLES    (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .game      (gif),
        .btn_db    (btn_db)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a level flips after N+1 consecutive raw samples of the
    // opposite value; it shows on btn_db 3 edges later and acts as a press 4 edges later.
    logic [4:0] level = '0;
    int         run [5];
    logic [4:0] lvl_d [5];
    int         tcnt = 0;
    logic       m_paused = 1'b0;
    logic [3:0] m_dir = 4'b0000;
    logic       m_tick = 1'b0;
    logic [4:0] m_db = '0;

    function automatic logic [10:0] outs();
        return {gif.up, gif.down, gif.left, gif.right, gif.move_tick, gif.paused, btn_db};
    endfunction

    function automatic logic [10:0] expv();
        return {m_dir, m_tick, m_paused, m_db};
    endfunction

    task automatic cycle(input logic [4:0] raw, input logic clr, input logic r);
        logic [4:0] press;
        {btn_center, btn_right, btn_left, btn_up, btn_down} = raw;
        gif.dir_clear = clr;
        rst = r;
        @(posedge clk);
        if (r) begin
            level = '0;
            for (int b = 0; b < 5; b++) begin
                run[b]   = 0;
                lvl_d[b] = '0;
            end
            tcnt = 0; m_paused = 1'b0; m_dir = 4'b0000; m_tick = 1'b0; m_db = '0;
        end else begin
            press = lvl_d[3] & ~lvl_d[4];
            m_db  = lvl_d[2];
            tcnt++;
            m_tick = ((tcnt % T) == 0) && !m_paused;
            if (press[4]) m_paused = !m_paused;
            if (press[3])      m_dir = 4'b0001;
            else if (press[2]) m_dir = 4'b0010;
            else if (press[1]) m_dir = 4'b1000;
            else if (press[0]) m_dir = 4'b0100;
            else if (clr)      m_dir = 4'b0000;
            for (int b = 0; b < 5; b++) begin
                if (raw[b] != level[b]) run[b]++;
                else run[b] = 0;
                if (run[b] == N + 1) begin
                    level[b] = ~level[b];
                    run[b]   = 0;
                end
            end
            for (int k = 4; k > 0; k--) lvl_d[k] = lvl_d[k-1];
            lvl_d[0] = level;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        tests++;
        if (outs() !== 11'b0) begin
            fails++;
            $display("FAIL reset: got %b want %b", outs(), 11'b0);
        end
    endtask

    task automatic test_idle_ticks();
        logic [20:1] seen = '0;
        logic [20:1] want = '0;
        want[8]  = 1'b1;
        want[16] = 1'b1;
        cycle('0, 1'b0, 1'b0);
        seen[1] = gif.move_tick;
        for (int i = 2; i <= 20; i++) begin
            cycle('0, 1'b0, 1'b0);
            seen[i] = gif.move_tick;
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL idle cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
        tests++;
        if (seen !== want) begin
            fails++;
            $display("FAIL idle_tick_grid: got %b want %b", seen, want);
        end
    endtask

    task automatic test_right_hold();
        for (int i = 0; i < 24; i++) begin
            cycle((i < 12) ? B_RIGHT : 5'b0, 1'b0, 1'b0);
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL right_hold cyc %0d: got %b want %b", i, outs(), expv());
            end
            if (i == 6 || i == 7) begin
                tests++;
                if (btn_db[3] !== (i == 7)) begin
                    fails++;
                    $display("FAIL right_db_edge cyc %0d: got %b want %b", i, btn_db[3], i == 7);
                end
            end
        end
        tests++;
        if (gif.right !== 1'b1) begin
            fails++;
            $display("FAIL right_latched: got %b want 1", gif.right);
        end
    endtask

    task automatic test_up_bounce();
        logic [4:0] pat = 5'b01101;
        logic       prev_up = 1'b0;
        int         rises = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(((i < 5) ? pat[i] : (i < 18)) ? B_UP : 5'b0, 1'b0, 1'b0);
            if (gif.up && !prev_up) rises++;
            prev_up = gif.up;
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL up_bounce cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
        tests++;
        if (rises != 1 || gif.right !== 1'b0) begin
            fails++;
            $display("FAIL up_single_latch: got rises=%0d right=%b want rises=1 right=0", rises, gif.right);
        end
    endtask

    task automatic test_coincident();
        for (int i = 0; i < 24; i++) begin
            cycle((i < 12) ? (B_LEFT | B_DOWN) : 5'b0, 1'b0, 1'b0);
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL left_down cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
        tests++;
        if ({gif.left, gif.down} !== 2'b10) begin
            fails++;
            $display("FAIL left_priority: got %b want 10", {gif.left, gif.down});
        end
        for (int i = 0; i < 24; i++) begin
            cycle((i < 12) ? B_UP : 5'b0, i == 8, 1'b0);
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL clear_vs_press cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
        tests++;
        if (gif.up !== 1'b1) begin
            fails++;
            $display("FAIL press_beats_clear: got %b want 1", gif.up);
        end
        cycle('0, 1'b1, 1'b0);
        tests++;
        if ({gif.up, gif.down, gif.left, gif.right} !== 4'b0000) begin
            fails++;
            $display("FAIL clear_alone: got %b want 0000", {gif.up, gif.down, gif.left, gif.right});
        end
    endtask

    task automatic test_pause();
        int ticks;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 24; i++) begin
                cycle((i < 12) ? B_CENTER : 5'b0, 1'b0, 1'b0);
                tests++;
                if (outs() !== expv()) begin
                    fails++;
                    $display("FAIL pause_press%0d cyc %0d: got %b want %b", p, i, outs(), expv());
                end
            end
            ticks = 0;
            for (int i = 0; i < ((p == 0) ? 3 * T : 2 * T); i++) begin
                cycle('0, 1'b0, 1'b0);
                ticks += int'(gif.move_tick);
                tests++;
                if (outs() !== expv()) begin
                    fails++;
                    $display("FAIL pause_run%0d cyc %0d: got %b want %b", p, i, outs(), expv());
                end
            end
            tests++;
            if (gif.paused !== (p == 0) || ticks != ((p == 0) ? 0 : 2)) begin
                fails++;
                $display("FAIL pause_state%0d: got paused=%b ticks=%0d want paused=%b ticks=%0d",
                         p, gif.paused, ticks, p == 0, (p == 0) ? 0 : 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(B_DOWN, 1'b0, 1'b0);
        cycle(B_DOWN, 1'b0, 1'b1);
        tests++;
        if (outs() !== 11'b0) begin
            fails++;
            $display("FAIL reset_mid_clear: got %b want %b", outs(), 11'b0);
        end
        for (int i = 0; i < 14; i++) begin
            cycle(B_DOWN, 1'b0, 1'b0);
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
        tests++;
        if (gif.down !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_down: got %b want 1", gif.down);
        end
    endtask

    task automatic test_random();
        logic [4:0] raw = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
            cycle(raw, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
            tests++;
            if (outs() !== expv()) begin
                fails++;
                $display("FAIL random cyc %0d: got %b want %b", i, outs(), expv());
            end
        end
    endtask

    initial begin
        gif.dir_clear = 1'b0;
        for (int b = 0; b < 5; b++) begin
            run[b]   = 0;
            lvl_d[b] = '0;
        end
        @(negedge clk);
        test_reset();
        test_idle_ticks();
        test_right_hold();
        test_up_bounce();
        test_coincident();
        test_pause();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
